// File: rtl/dsp_iir_sequencer_pkg.sv
// Shared types, constants and the round/saturate helper for the
// time-multiplexed biquad IIR sequencer.
//   sample_t    : default-width signed sample/coefficient
//   coef_idx_e  : coefficient slot / tap index (b0, b1, b2, a1, a2)
//   state_e     : sequencer FSM states
//   sat_round() : round-half-up, arithmetic shift by frac, clamp to width bits
package dsp_iir_sequencer_pkg;

  localparam int WS_DEFAULT   = 16;
  localparam int EWS_DEFAULT  = 40;
  localparam int FRAC_DEFAULT = 8;
  localparam int UNITY_COEF   = 1 << FRAC_DEFAULT;
  localparam int NUM_TAPS     = 5;

  typedef logic signed [WS_DEFAULT-1:0] sample_t;

  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coef_idx_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Works on a 64-bit sign-extended accumulator so any legal width can use it;
  // the caller truncates the clamped result to its sample width.
  function automatic logic signed [63:0] sat_round(
    input logic signed [63:0] acc,
    input int unsigned        frac,
    input int unsigned        width
  );
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    rounded = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (width - 1));
    if (rounded > max_v)      sat_round = max_v;
    else if (rounded < min_v) sat_round = min_v;
    else                      sat_round = rounded;
  endfunction

endpackage

// File: rtl/dsp_iir_sequencer_mac.sv
// Shared signed multiply-accumulate unit: one ws x ws product per cycle,
// optionally negated, sign-extended and added into an ews-bit accumulator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the accumulator (wins over en)
//   en         : accumulate one product this cycle
//   neg        : subtract the product instead of adding it
//   coef, operand : signed multiplicands
//   acc        : running signed accumulator
module dsp_iir_sequencer_mac #(
  parameter int ws  = 16,
  parameter int ews = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  neg,
  input  logic signed [ws-1:0]  coef,
  input  logic signed [ws-1:0]  operand,
  output logic signed [ews-1:0] acc
);

  logic signed [2*ws-1:0] prod;
  logic signed [ews-1:0]  prod_ext;
  logic signed [ews-1:0]  term;

  always_comb begin
    prod     = (2*ws)'(coef) * (2*ws)'(operand);
    prod_ext = ews'(prod);
    term     = neg ? -prod_ext : prod_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + term;
  end

endmodule

// File: rtl/dsp_iir_sequencer.sv
// Time-multiplexed biquad IIR:
//   y[n] = (b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]) >> FRAC
// with rounding and saturation, using one shared MAC over five tap cycles.
// Ports:
//   iCLK, iRST_N               : clock, asynchronous active-low reset
//   iIn/iInValid/oInReady      : sample input handshake
//   oOut/oOutValid/iOutReady   : registered result handshake
//   iCoefWe/iCoefAddr/iCoefData: shadow coefficient write (0=b0..4=a2)
//   iBypass                    : output the input sample, same timing
//   iClear                     : synchronous clear of x1, x2, y1, y2
import dsp_iir_sequencer_pkg::*;

module dsp_iir_sequencer #(
  parameter int ws   = WS_DEFAULT,
  parameter int ews  = EWS_DEFAULT,
  parameter int FRAC = FRAC_DEFAULT
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic signed [ws-1:0] iIn,
  input  logic                 iInValid,
  output logic                 oInReady,
  output logic signed [ws-1:0] oOut,
  output logic                 oOutValid,
  input  logic                 iOutReady,
  input  logic                 iCoefWe,
  input  logic [2:0]           iCoefAddr,
  input  logic signed [ws-1:0] iCoefData,
  input  logic                 iBypass,
  input  logic                 iClear
);

  localparam logic signed [ws-1:0] UNITY = ws'(1) << FRAC;
  localparam logic [2:0]           DRAIN = 3'(NUM_TAPS);

  state_e                state, state_next;
  logic [2:0]            tap;
  logic signed [ws-1:0]  x0, x1, x2, y1, y2;
  logic                  bypass;
  logic signed [ws-1:0]  shadow_coef [NUM_TAPS];
  logic signed [ws-1:0]  active_coef [NUM_TAPS];

  logic                  mac_clr, mac_en, mac_neg;
  logic signed [ws-1:0]  coef_sel, operand_sel;
  logic signed [ews-1:0] acc;
  logic signed [ws-1:0]  result;

  dsp_iir_sequencer_mac #(.ws(ws), .ews(ews)) u_mac (
    .clk    (iCLK),
    .rst_n  (iRST_N),
    .clr    (mac_clr),
    .en     (mac_en),
    .neg    (mac_neg),
    .coef   (coef_sel),
    .operand(operand_sel),
    .acc    (acc)
  );

  // Taps 0..4 accumulate; tap 5 is a drain cycle so the result is formed
  // from the completed accumulator on the MAC->OUT edge.
  always_comb begin
    state_next  = state;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    mac_neg     = (tap >= 3'(A1));
    oInReady    = 1'b0;
    coef_sel    = '0;
    operand_sel = '0;
    case (state)
      IDLE: begin
        oInReady = 1'b1;
        if (iInValid) begin
          state_next = MAC;
          mac_clr    = 1'b1;
        end
      end
      MAC: begin
        if (tap == DRAIN) state_next = OUT;
        else              mac_en     = 1'b1;
      end
      OUT: begin
        if (iOutReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (tap < DRAIN) coef_sel = active_coef[tap];
    case (tap)
      B0:      operand_sel = x0;
      B1:      operand_sel = x1;
      B2:      operand_sel = x2;
      A1:      operand_sel = y1;
      A2:      operand_sel = y2;
      default: operand_sel = '0;
    endcase
    result = bypass ? x0 : ws'(sat_round(64'(acc), FRAC, ws));
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      tap       <= '0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      bypass    <= 1'b0;
      oOut      <= '0;
      oOutValid <= 1'b0;
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        shadow_coef[i] <= (i == 0) ? UNITY : '0;
        active_coef[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      state <= state_next;
      if (iCoefWe && iCoefAddr <= 3'(A2))
        shadow_coef[iCoefAddr] <= iCoefData;
      case (state)
        IDLE: begin
          if (iInValid) begin
            x0     <= iIn;
            bypass <= iBypass;
            tap    <= '0;
            for (int unsigned i = 0; i < NUM_TAPS; i++)
              active_coef[i] <= shadow_coef[i];
          end
        end
        MAC: begin
          if (tap == DRAIN) begin
            oOut      <= result;
            oOutValid <= 1'b1;
            x2        <= x1;
            x1        <= x0;
            y2        <= y1;
            y1        <= result;
          end else begin
            tap <= tap + 3'd1;
          end
        end
        OUT: begin
          if (iOutReady) oOutValid <= 1'b0;
        end
        default: ;
      endcase
      // Clear overrides the history shift above.
      if (iClear) begin
        x1 <= '0;
        x2 <= '0;
        y1 <= '0;
        y2 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_iir_sequencer.sv
// Directed self-checking bench for dsp_iir_sequencer with hand-computed
// expected outputs (Q8.8 coefficients, 16-bit samples).
import dsp_iir_sequencer_pkg::*;

module tb_dsp_iir_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  sample_t    din;
  logic       in_valid;
  logic       in_ready;
  sample_t    dout;
  logic       out_valid;
  logic       out_ready;
  logic       coef_we;
  logic [2:0] coef_addr;
  sample_t    coef_data;
  logic       bypass;
  logic       clear;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsp_iir_sequencer #(.ws(16), .ews(40), .FRAC(8)) dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .iIn      (din),
    .iInValid (in_valid),
    .oInReady (in_ready),
    .oOut     (dout),
    .oOutValid(out_valid),
    .iOutReady(out_ready),
    .iCoefWe  (coef_we),
    .iCoefAddr(coef_addr),
    .iCoefData(coef_data),
    .iBypass  (bypass),
    .iClear   (clear)
  );

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    din       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    bypass    = 1'b0;
    clear     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_coef(input int addr, input int data);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 16'(data);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Offers x, waits for the accept edge, then returns the result and the
  // number of cycles from accept to oOutValid (20 means it never came).
  task automatic send(input int x, output int y, output int lat);
    int n;
    @(negedge clk);
    din      = 16'(x);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    y = dout;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int y, lat, seen;

    // Reset defaults and unity passthrough
    do_reset();
    #1;
    check("rst_out", dout, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    send(1000, y, lat);
    check("unity_1000", y, 1000);
    check("latency", lat, 6);
    send(-1234, y, lat);
    check("unity_neg", y, -1234);

    // FIR moving average and rounding
    do_reset();
    write_coef(B0, 128);
    write_coef(B1, 128);
    send(256, y, lat); check("avg0", y, 128);
    send(256, y, lat); check("avg1", y, 256);
    send(0, y, lat);   check("avg2", y, 128);
    do_reset();
    write_coef(B0, 128);
    send(3, y, lat);   check("round_3", y, 2);

    // Recursive decay
    do_reset();
    write_coef(B0, 256);
    write_coef(A1, -128);
    send(256, y, lat); check("decay0", y, 256);
    send(0, y, lat);   check("decay1", y, 128);
    send(0, y, lat);   check("decay2", y, 64);
    send(0, y, lat);   check("decay3", y, 32);

    // Saturation
    do_reset();
    write_coef(B0, 1024);
    send(20000, y, lat);  check("sat_pos", y, 32767);
    send(-20000, y, lat); check("sat_neg", y, -32768);

    // Backpressure: output held, extra input ignored
    do_reset();
    out_ready = 1'b0;
    send(500, y, lat);
    check("bp_lat", lat, 6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      din      = 16'sd777;
      check("bp_hold_out", dout, 500);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
    end
    @(negedge clk);
    din       = 16'sd321;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_hs_valid", out_valid, 0);
    check("bp_hs_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check("bp_accept_next", in_ready, 0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_next_out", dout, 321);

    // Coefficient write during MAC applies only to the next sample
    do_reset();
    @(negedge clk);
    din      = 16'sd100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    write_coef(B0, 512);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("midwr_old", dout, 100);
    send(100, y, lat);
    check("midwr_new", y, 200);

    // Clear wipes history between samples
    do_reset();
    write_coef(B0, 256);
    write_coef(A1, -128);
    send(256, y, lat); check("clr_pre", y, 256);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    send(100, y, lat); check("clr_post", y, 100);

    // Bypass output, and y history takes the bypassed sample
    do_reset();
    write_coef(B0, 512);
    bypass = 1'b1;
    send(300, y, lat);
    check("byp_out", y, 300);
    check("byp_lat", lat, 6);
    bypass = 1'b0;
    write_coef(A1, -128);
    send(0, y, lat);
    check("byp_yhist", y, 150);

    // Reset during MAC discards the sample and restores unity coefficients
    do_reset();
    write_coef(B0, 512);
    @(negedge clk);
    din      = 16'sd1000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_out", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("midrst_no_out", seen, 0);
    send(50, y, lat);
    check("midrst_unity", y, 50);
    check("unity_const", UNITY_COEF, 256 * y / 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
